// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- receive half of the UART controller.
//
// Deserialises an asynchronous, idle-high serial line into 8- or 9-bit words
// (LSB first, no parity, 1 or 2 stop bits). Every completed frame loads the
// held data register. A one-cycle valid strobe marks the load, and a coincident
// frame_err strobe flags any stop-bit sample that read 0.
//
// The frame format comes from the 12-bit control word, packed MSB to LSB as
//   control[11:3] br_div  clocks per bit (values below 2 behave as 2)
//   control[2]    word    0 = 8 data bits, 1 = 9 data bits
//   control[1]    stop    0 = 1 stop bit,  1 = 2 stop bits
//   control[0]    en      receiver enable
// br_div, word and stop are captured at the start edge, so the frame in flight
// is unaffected by later writes. Dropping en aborts a frame at any time.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   rx_in      in   serial line, asynchronous to clk
//   control    in   frame format / enable (see above)
//   data       out  last received word, LSB-aligned, bit 8 = 0 for 8-bit frames
//   valid      out  one-cycle strobe when data is loaded
//   frame_err  out  one-cycle strobe with valid when a stop bit read 0
//   idle       out  high only while waiting for a start edge
// -----------------------------------------------------------------------------
module uart_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_in,
   input  logic [11:0] control,
   output logic [8:0]  data,
   output logic        valid,
   output logic        frame_err,
   output logic        idle
);

   // Receiver states. StDone is the single cycle after the last stop sample in
   // which the word is published.
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StStop   = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;
   localparam logic [2:0] StWaitHi = 3'd5;

   // Control word fields.
   logic [8:0] ctrl_br_div;
   logic       ctrl_word;
   logic       ctrl_stop;
   logic       ctrl_en;

   assign ctrl_br_div = control[11:3];
   assign ctrl_word   = control[2];
   assign ctrl_stop   = control[1];
   assign ctrl_en     = control[0];

   // Effective divider: at least two clocks per bit so the half-bit offset
   // to the start-bit centre is never zero.
   logic [8:0] ctrl_eff_div;
   logic [8:0] ctrl_half_load;

   assign ctrl_eff_div   = (ctrl_br_div < 9'd2) ? 9'd2 : ctrl_br_div;
   assign ctrl_half_load = (ctrl_eff_div >> 1) - 9'd1;

   // Two-flop synchroniser on the line, reset to the idle level.
   logic [1:0] sync_q;
   logic       rxs;

   assign rxs = sync_q[1];

   // State and datapath registers.
   logic [2:0] state_q,   state_d;
   logic [8:0] cnt_q,     cnt_d;
   logic [8:0] div_q,     div_d;
   logic       word_q,    word_d;
   logic       stop_q,    stop_d;
   logic [3:0] bit_idx_q, bit_idx_d;
   logic [8:0] shift_q,   shift_d;
   logic       err_q,     err_d;
   logic [8:0] data_q,    data_d;
   logic       valid_q,   valid_d;
   logic       ferr_q,    ferr_d;

   logic       cnt_zero;
   logic [3:0] last_bit;
   logic       last_stop;

   assign cnt_zero  = (cnt_q == 9'd0);
   assign last_bit  = word_q ? 4'd8 : 4'd7;
   // In StStop bit_idx counts stop samples already taken (0 or 1).
   assign last_stop = (bit_idx_q[0] == stop_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      word_d    = word_q;
      stop_d    = stop_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      err_d     = err_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      if (state_q != StIdle && !ctrl_en) begin
         // Abort: drop the frame silently, data keeps its last value.
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (ctrl_en && !rxs) begin
                  div_d   = ctrl_eff_div;
                  word_d  = ctrl_word;
                  stop_d  = ctrl_stop;
                  cnt_d   = ctrl_half_load;
                  state_d = StStart;
               end
            end

            StStart: begin
               if (cnt_zero) begin
                  if (rxs) begin
                     // Line went back high before mid start bit: glitch.
                     state_d = StIdle;
                  end else begin
                     cnt_d     = div_q - 9'd1;
                     bit_idx_d = 4'd0;
                     shift_d   = 9'd0;
                     err_d     = 1'b0;
                     state_d   = StData;
                  end
               end else begin
                  cnt_d = cnt_q - 9'd1;
               end
            end

            StData: begin
               if (cnt_zero) begin
                  shift_d[bit_idx_q] = rxs;
                  cnt_d              = div_q - 9'd1;
                  if (bit_idx_q == last_bit) begin
                     bit_idx_d = 4'd0;
                     state_d   = StStop;
                  end else begin
                     bit_idx_d = bit_idx_q + 4'd1;
                  end
               end else begin
                  cnt_d = cnt_q - 9'd1;
               end
            end

            StStop: begin
               if (cnt_zero) begin
                  if (!rxs) begin
                     err_d = 1'b1;
                  end
                  if (last_stop) begin
                     state_d = StDone;
                  end else begin
                     cnt_d     = div_q - 9'd1;
                     bit_idx_d = bit_idx_q + 4'd1;
                  end
               end else begin
                  cnt_d = cnt_q - 9'd1;
               end
            end

            StDone: begin
               // Bit 8 is only meaningful for 9-bit frames.
               data_d  = {word_q & shift_q[8], shift_q[7:0]};
               valid_d = 1'b1;
               ferr_d  = err_q;
               // After a framing error the line may be in a break; wait for it
               // to go high so the low level is not taken as a new start bit.
               state_d = err_q ? StWaitHi : StIdle;
            end

            StWaitHi: begin
               if (rxs) begin
                  state_d = StIdle;
               end
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= 2'b11;
         state_q   <= StIdle;
         cnt_q     <= 9'd0;
         div_q     <= 9'd2;
         word_q    <= 1'b0;
         stop_q    <= 1'b0;
         bit_idx_q <= 4'd0;
         shift_q   <= 9'd0;
         err_q     <= 1'b0;
         data_q    <= 9'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx_in};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         word_q    <= word_d;
         stop_q    <= stop_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         err_q     <= err_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign idle      = (state_q == StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// A serial driver plays the transmitter. For each frame it predicts, from the
// frame timing rules, the cycle on which valid must strobe and the word and
// error flag it must carry; a compare process checks valid, frame_err and the
// held data register against that prediction on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   logic        clk;
   logic        rst;
   logic        rx_in;
   logic [11:0] control;
   logic [8:0]  data;
   logic        valid;
   logic        frame_err;
   logic        idle;

   uart_rx dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .control   (control),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .idle      (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [8:0] data;
      logic       ferr;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] data_m;
   bit         cmp_en;
   int         nvalid = 0;
   int         last_v_cyc = -1;
   logic [8:0] last_v_data = '0;
   logic       last_v_ferr = 1'b0;
   logic       last_v_idle = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [11:0] mk(input int br, input bit w, input bit s, input bit e);
      logic [31:0] b;
      b = br;
      return {b[8:0], w, s, e};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; must be called 1 time unit after a rising edge. The line
   // is left at the last stop-bit level. With push set, the expected strobe is
   // queued: the receiver sees the fall 3 edges later (t), samples the last
   // stop bit at t + eff/2 + (nbits+nstop)*eff and publishes one edge later.
   task automatic send_frame(input logic [8:0] d, input int nbits, input int eff,
                             input logic [1:0] stops, input int nstop, input bit push);
      exp_t e;
      if (push) begin
         e.cyc  = cyc + 3 + eff / 2 + (nbits + nstop) * eff + 1;
         e.data = (nbits == 9) ? d : {1'b0, d[7:0]};
         e.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
         exp_q.push_back(e);
      end
      rx_in = 1'b0;
      tick(eff);
      for (int k = 0; k < nbits; k++) begin
         rx_in = d[k];
         tick(eff);
      end
      for (int j = 0; j < nstop; j++) begin
         rx_in = stops[j];
         tick(eff);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (cmp_en) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("valid_strobe", valid, 1);
            chk("frame_err_on_valid", frame_err, e.ferr);
            chk("data_on_valid", data, e.data);
            data_m = e.data;
         end else begin
            chk("no_valid", valid, 0);
            chk("no_frame_err", frame_err, 0);
            chk("data_held", data, data_m);
         end
      end
      if (valid) begin
         nvalid++;
         last_v_cyc  = cyc;
         last_v_data = data;
         last_v_ferr = frame_err;
         last_v_idle = idle;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  c0;
      int  nv0;
      bit  found;

      rx_in   = 1'b1;
      control = mk(8, 0, 0, 1);
      data_m  = '0;
      cmp_en  = 1'b0;
      rst     = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("reset_data", data, 0);
      chk("reset_valid", valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_idle", idle, 1);
      cmp_en = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(5);

      // 8N1, br_div = 8: valid 80 edges after the line falls (t + 77).
      c0 = cyc;
      send_frame(9'h08E, 8, 8, 2'b11, 1, 1);
      tick(10);
      chk("8n1_valid_cycle", last_v_cyc, c0 + 80);
      chk("8n1_data", last_v_data, 9'h08E);
      chk("8n1_ferr", last_v_ferr, 0);
      chk("8n1_idle_with_valid", last_v_idle, 1);

      // 9 data bits, 2 stop bits, odd divider, back-to-back frames.
      control = mk(5, 1, 1, 1);
      tick(2);
      c0  = cyc;
      nv0 = nvalid;
      send_frame(9'h081, 9, 5, 2'b11, 2, 1);
      send_frame(9'h1FE, 9, 5, 2'b11, 2, 1);
      rx_in = 1'b1;
      tick(12);
      chk("9b_two_valids", nvalid - nv0, 2);
      chk("9b_last_cycle", last_v_cyc, c0 + 121);
      chk("9b_last_data", last_v_data, 9'h1FE);

      // br_div = 1 behaves as 2 clocks per bit.
      control = mk(1, 0, 0, 1);
      tick(2);
      c0 = cyc;
      send_frame(9'h03C, 8, 2, 2'b11, 1, 1);
      tick(8);
      chk("div1_valid_cycle", last_v_cyc, c0 + 23);
      chk("div1_data", last_v_data, 9'h03C);

      // Framing error with the line held low afterwards.
      control = mk(8, 0, 0, 1);
      tick(2);
      c0 = cyc;
      send_frame(9'h055, 8, 8, 2'b00, 1, 1);
      tick(30);
      chk("ferr_valid_cycle", last_v_cyc, c0 + 80);
      chk("ferr_flag", last_v_ferr, 1);
      chk("ferr_data", last_v_data, 9'h055);
      chk("ferr_idle_while_low", idle, 0);
      rx_in = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (idle) found = 1'b1;
      end
      chk("ferr_idle_after_high", found, 1);
      tick(20);

      // False start: 3-clock glitch.
      nv0   = nvalid;
      rx_in = 1'b0;
      tick(3);
      rx_in = 1'b1;
      chk("glitch_start_seen", idle, 0);
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (idle) found = 1'b1;
      end
      chk("glitch_idle_within_6", found, 1);
      tick(10);
      chk("glitch_no_valid", nvalid - nv0, 0);

      // word changed to 1 mid-frame: current frame still 8 bits.
      fork
         send_frame(9'h1A5, 8, 8, 2'b11, 1, 1);
         begin
            tick(30);
            control[2] = 1'b1;
         end
      join
      tick(10);
      chk("word_change_data", last_v_data, 9'h0A5);
      control[2] = 1'b0;
      tick(5);

      // en dropped mid-frame.
      nv0 = nvalid;
      fork
         send_frame(9'h033, 8, 8, 2'b11, 1, 0);
         begin
            tick(40);
            control[0] = 1'b0;
            tick(1);
            chk("en_drop_idle", idle, 1);
         end
      join
      rx_in = 1'b1;
      tick(5);
      control[0] = 1'b1;
      tick(10);
      chk("en_drop_no_valid", nvalid - nv0, 0);

      // Reset during DATA.
      fork
         send_frame(9'h0C3, 8, 8, 2'b11, 1, 0);
         begin
            tick(30);
            rst    = 1'b0;
            data_m = '0;
            #1;
            chk("rst_mid_data", data, 0);
            chk("rst_mid_valid", valid, 0);
            chk("rst_mid_idle", idle, 1);
         end
      join
      rx_in = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(3);
      c0 = cyc;
      send_frame(9'h0C3, 8, 8, 2'b11, 1, 1);
      tick(10);
      chk("post_rst_cycle", last_v_cyc, c0 + 80);
      chk("post_rst_data", last_v_data, 9'h0C3);

      tick(20);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART controller. Deserialises the asynchronous serial line driven by the transmitter (or an external device) into 8- or 9-bit words, using the same `ctrl_reg_t` control word as the transmit path. Each received word is presented on a held data register with a one-cycle `valid` strobe and a framing-error flag. The block sits directly downstream of `uart_tx` in loopback and feeds the receive data path of the controller.

## Interface
- No parameters. Frame format comes from `control`, of type `ctrl_reg_t` in `data_types_pkg`, with fields `br_div`, `word`, `stop` and `en`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  serial line, idle high, asynchronous to `clk`.
- `control`  in  12  `ctrl_reg_t`. `br_div` = clocks per bit; `word` 0 = 8 data bits, 1 = 9 data bits; `stop` 0 = 1 stop bit, 1 = 2 stop bits; `en` = receiver enable.
- `data`  out  9  last received word, LSB-aligned. Bit 8 = 0 when `word` = 0.
- `valid`  out  1  one-cycle strobe, asserted when `data` is updated.
- `frame_err`  out  1  one-cycle strobe, coincident with `valid`, when any stop-bit sample is 0.
- `idle`  out  1  high in IDLE state only.

## Operation
- `rx_in` passes through a 2-flop synchroniser, reset to 1. All logic below uses the synchronised value `rxs`.
- Frame format: LSB first, no parity.
- States:
  - **IDLE**: `idle` = 1.
    - Leave only when `en` = 1 and `rxs` = 0. Go to START.
    - On this transition, latch `br_div`, `word` and `stop`. Later changes to `control` do not affect the current frame.
    - Load `cnt` = floor(eff_div/2) − 1, where eff_div = max(`br_div`, 2).
  - **START**:
    - `cnt` decrements once per clock. At `cnt` = 0, sample `rxs`.
    - Sample = 1: false start. Go to IDLE, no output.
    - Sample = 0: load `cnt` = eff_div − 1, clear `bit_idx`, go to DATA.
  - **DATA**:
    - At each `cnt` = 0, shift `rxs` into the shift register at position `bit_idx`, reload `cnt`, increment `bit_idx`.
    - After bit 7 (`word` = 0) or bit 8 (`word` = 1), go to STOP.
  - **STOP**:
    - Take 1 or 2 samples, one per bit period; record an error if any sample is 0.
    - After the final stop sample, on the next edge: load `data`, pulse `valid`, pulse `frame_err` if an error was recorded.
    - No error: go to IDLE. Error: go to WAIT_HI.
  - **WAIT_HI**: stay until `rxs` = 1 (break or line stuck low), then go to IDLE.
- `en` deasserted in any non-IDLE state: abort the frame and return to IDLE on the next edge. No `valid`; `data` keeps its last value.
- No overrun detection. A new frame overwrites `data`; the consumer must capture it on `valid`.
- Width rules:
  - `cnt` is as wide as `br_div`.
  - `bit_idx` is 4 bits.
  - Unused `data[8]` is forced to 0 when the latched `word` = 0.

## Timing
- Reset values: `data` = 0, `valid` = 0, `frame_err` = 0, `idle` = 1, synchroniser flops = 1, state = IDLE.
- Reset mid-frame returns the block to IDLE immediately, with no strobe.
- Cycle numbering: t = the edge at which IDLE sees `rxs` = 0. That is the 3rd clock edge after `rx_in` falls.
- Samples with H = floor(eff_div/2):
  - start bit at t+H;
  - data bit k (k = 0..N−1) at t+H+(k+1)·eff_div;
  - stop bit j (j = 0..S−1) at t+H+(N+1+j)·eff_div.
- `valid` is high for the single cycle after the last stop sample.
- Example, `br_div` = 8, 8N1: `valid` high in cycle t+77, `idle` high again from t+77.
- A new start edge can be accepted in the cycle `valid` is high. Back-to-back frames with no idle gap are therefore received without loss.
- A line glitch shorter than H clocks is rejected as a false start.

## Test plan
- **8N1:** `br_div` = 8, `word` = 0, `stop` = 0, `en` = 1. Drive 0x8E as a serial frame. Expect `data` = 0x08E, exactly one `valid` at t+77, `frame_err` = 0.
- **9-bit loopback:** connect `uart_tx.tx_out` → `rx_in`. `word` = 1, `stop` = 1. Send 0x81, then 0x1FE. Expect `data` = 0x081, then 0x1FE; one `valid` each; no `frame_err`.
- **Framing error:** 8N1 frame 0x55 with the stop bit driven 0 and the line held low for 30 more clocks. Expect `valid` and `frame_err` both pulse with `data` = 0x055. `idle` stays 0 until the line returns high, then no spurious frame.
- **False start:** 3-clock low glitch on `rx_in`, `br_div` = 8. Expect no `valid`, `idle` = 1 within 6 clocks of the glitch, `data` unchanged.
- **Mid-frame abort:** change `word` 0 → 1 mid-frame, then deassert `en` mid-frame. Expect the `word` change has no effect on the current frame (8 bits still received). Expect the `en` drop returns `idle` = 1 next edge with no `valid`.
- **Reset mid-frame:** pull `rst` low during DATA. Expect `data` = 0, `valid` = 0, `idle` = 1 asynchronously. A frame sent after release receives correctly.
